// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC, latency-1 memory requests, small fetch buffer, valid/ready to decode.
// Optional HALT stop on opcode 4'hF when IF_HALT_DETECT_EN is defined.
module instruction_fetch #(
  parameter int              PC_W       = 8,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic            IF_clock,
  input  logic            IF_reset_n,
  output logic            IF_mem_req,
  output logic [PC_W-1:0] IF_mem_addr,
  input  logic [15:0]     IF_mem_rdata,
  input  logic            IF_redirect,
  input  logic [PC_W-1:0] IF_redirect_pc,
  output logic            IF_valid,
  input  logic            IF_ready,
  output logic [15:0]     IF_instruction,
  output logic [PC_W-1:0] IF_pc,
  output logic            IF_halted
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]     buf_instr [FIFO_DEPTH];
  logic [PC_W-1:0] buf_pc    [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic [PC_W-1:0] fetch_pc, inflight_pc;
  logic            inflight, halted;
  logic            empty, pop, push, halt_hit;

  assign empty = (count == '0);
  assign pop   = IF_valid && IF_ready && !IF_redirect;
  // inflight is cleared by a redirect edge, so a response overtaken by a redirect never lands
  assign push  = inflight && !IF_redirect;

`ifdef IF_HALT_DETECT_EN
  assign halt_hit = push && (IF_mem_rdata[15:12] == 4'hF);
`else
  assign halt_hit = 1'b0;
`endif

  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

  assign IF_mem_req     = IF_reset_n && !IF_redirect && !halted &&
                          (occupancy < (CW+1)'(FIFO_DEPTH));
  assign IF_mem_addr    = IF_reset_n ? fetch_pc : '0;
  assign IF_valid       = !empty;
  assign IF_instruction = empty ? 16'h0 : buf_instr[rd_ptr];
  assign IF_pc          = empty ? '0 : buf_pc[rd_ptr];
  assign IF_halted      = halted;

  always_ff @(posedge IF_clock or negedge IF_reset_n) begin
    if (!IF_reset_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      halted      <= 1'b0;
    end else if (IF_redirect) begin
      fetch_pc <= IF_redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      halted   <= 1'b0;
    end else begin
      if (IF_mem_req) begin
        fetch_pc    <= fetch_pc + PC_W'(1);
        inflight_pc <= fetch_pc;
      end
      // a request issued alongside a HALT capture is dropped on return
      inflight <= IF_mem_req && !halt_hit;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (halt_hit) halted <= 1'b1;
    end
  end

  always_ff @(posedge IF_clock) begin
    if (push) begin
      buf_instr[wr_ptr] <= IF_mem_rdata;
      buf_pc[wr_ptr]    <= inflight_pc;
    end
  end

endmodule
